// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Width and address-map helpers shared by the conv layer RTL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    // Full-precision accumulator width for a K x K x CH_IN dot product.
    function automatic int acc_bits(input int data_bits, input int weight_bits,
                                    input int k, input int ch_in);
        return data_bits + weight_bits + $clog2(k * k * ch_in);
    endfunction

    function automatic int bias_base(input int ch_out, input int ch_in, input int k);
        return ch_out * ch_in * k * k;
    endfunction

    function automatic int addr_w(input int ch_out, input int ch_in, input int k);
        return $clog2(bias_base(ch_out, ch_in, k) + ch_out);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_window_buf.sv
// ============================================================================
// Module      : conv_window_buf
// Description : K-1 line buffers plus a K x K shift window for one channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_buf #(
    parameter int W         = 12,
    parameter int K         = 3,
    parameter int DATA_BITS = 12,
    parameter int COL_W     = 4,
    parameter int ROW_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid,
    input  logic [DATA_BITS-1:0]         pixel,
    input  logic [COL_W-1:0]             col,
    input  logic [ROW_W-1:0]             row,
    output logic [K*K*DATA_BITS-1:0]     win,
    output logic                         win_valid
);

    logic [DATA_BITS-1:0] lines  [K-1][W];
    logic [DATA_BITS-1:0] taps   [K][K];
    logic [DATA_BITS-1:0] column [K];

    // column[K-1] is the current row; lines[j] holds row (current - 1 - j).
    always_comb begin
        column[K-1] = pixel;
        for (int j = 0; j < K - 1; j++) begin
            column[K-2-j] = lines[j][col];
        end
    end

    always_ff @(posedge clk) begin
        if (valid) begin
            lines[0][col] <= pixel;
            for (int j = 1; j < K - 1; j++) begin
                lines[j][col] <= lines[j-1][col];
            end
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K - 1; kx++) begin
                    taps[ky][kx] <= taps[ky][kx+1];
                end
                taps[ky][K-1] <= column[ky];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
        end else begin
            win_valid <= valid && (int'(row) >= K - 1) && (int'(col) >= K - 1);
        end
    end

    for (genvar ky = 0; ky < K; ky++) begin : g_ky
        for (genvar kx = 0; kx < K; kx++) begin : g_kx
            assign win[(ky*K+kx)*DATA_BITS +: DATA_BITS] = taps[ky][kx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_layer_param.sv
// ============================================================================
// Module      : conv_layer_param
// Description : Multi-channel KxK convolution with loadable weights/biases,
//               rounding, saturation, optional ReLU and frame tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_layer_param
    import cnn_pkg::*;
#(
    parameter int W           = 12,
    parameter int H           = 12,
    parameter int CH_IN       = 3,
    parameter int CH_OUT      = 3,
    parameter int K           = 3,
    parameter int DATA_BITS   = 12,
    parameter int WEIGHT_BITS = 8,
    parameter int SHIFT       = 1,
    parameter int ADDR_W      = addr_w(CH_OUT, CH_IN, K)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic [CH_IN*DATA_BITS-1:0]    data_in,
    input  logic                          relu_en,
    input  logic                          cfg_we,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [WEIGHT_BITS-1:0]        cfg_data,
    output logic [CH_OUT*DATA_BITS-1:0]   data_out,
    output logic                          valid_out,
    output logic                          frame_done,
    output logic                          cfg_err
);

    localparam int TAPS      = K * K;
    localparam int NUM_W     = bias_base(CH_OUT, CH_IN, K);
    localparam int NUM_ENT   = NUM_W + CH_OUT;
    localparam int ACC_BITS  = acc_bits(DATA_BITS, WEIGHT_BITS, K, CH_IN);
    localparam int PROD_BITS = DATA_BITS + WEIGHT_BITS;
    localparam int SUM_BITS  = ACC_BITS + 2;
    localparam int COL_W     = cnt_w(W);
    localparam int ROW_W     = cnt_w(H);
    localparam logic signed [SUM_BITS-1:0] SAT_MAX = SUM_BITS'((1 <<< (DATA_BITS-1)) - 1);
    localparam logic signed [SUM_BITS-1:0] SAT_MIN = SUM_BITS'(-(1 <<< (DATA_BITS-1)));

    logic [COL_W-1:0]               col;
    logic [ROW_W-1:0]               row;
    logic                           relu_lat;
    logic signed [WEIGHT_BITS-1:0]  mem [NUM_ENT];
    logic [TAPS*DATA_BITS-1:0]      win [CH_IN];
    logic [CH_IN-1:0]               win_ok;
    logic                           win_valid, v1, v2;
    logic                           last_w, last1, last2;
    logic                           relu_w, relu1, relu2;
    logic                           first_px, last_px, busy;

    logic signed [PROD_BITS-1:0]    prod  [CH_OUT][CH_IN*TAPS];
    logic signed [ACC_BITS-1:0]     acc_c [CH_OUT];
    logic signed [ACC_BITS-1:0]     acc   [CH_OUT];
    logic [DATA_BITS-1:0]           res   [CH_OUT];

    assign first_px  = (row == '0) && (col == '0);
    assign last_px   = (row == ROW_W'(H-1)) && (col == COL_W'(W-1));
    assign win_valid = &win_ok;
    assign busy      = !first_px || win_valid || v1 || v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            relu_lat <= 1'b0;
        end else if (valid_in) begin
            if (first_px) relu_lat <= relu_en;
            if (col == COL_W'(W-1)) begin
                col <= '0;
                row <= (row == ROW_W'(H-1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Weight RAM: no reset, writes only land while the datapath is idle.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy && (int'(cfg_addr) < NUM_ENT)) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cfg_err <= 1'b0;
        else     cfg_err <= cfg_we && busy;
    end

    for (genvar i = 0; i < CH_IN; i++) begin : g_ch
        conv_window_buf #(
            .W         (W),
            .K         (K),
            .DATA_BITS (DATA_BITS),
            .COL_W     (COL_W),
            .ROW_W     (ROW_W)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .valid     (valid_in),
            .pixel     (data_in[i*DATA_BITS +: DATA_BITS]),
            .col       (col),
            .row       (row),
            .win       (win[i]),
            .win_valid (win_ok[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= win_valid;
            v2 <= v1;
        end
    end

    // ReLU mode is captured per window so a new frame cannot alter in-flight results.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            last_w <= last_px;
            relu_w <= first_px ? relu_en : relu_lat;
        end
        last1 <= last_w;
        relu1 <= relu_w;
        last2 <= last1;
        relu2 <= relu1;
        for (int o = 0; o < CH_OUT; o++) begin
            for (int i = 0; i < CH_IN; i++) begin
                for (int t = 0; t < TAPS; t++) begin
                    prod[o][i*TAPS+t] <= PROD_BITS'($signed(win[i][t*DATA_BITS +: DATA_BITS]))
                                       * PROD_BITS'(mem[(o*CH_IN+i)*TAPS+t]);
                end
            end
            acc[o] <= acc_c[o];
        end
    end

    always_comb begin
        for (int o = 0; o < CH_OUT; o++) begin
            acc_c[o] = '0;
            for (int t = 0; t < CH_IN * TAPS; t++) begin
                acc_c[o] = acc_c[o] + ACC_BITS'(prod[o][t]);
            end
        end
    end

    for (genvar o = 0; o < CH_OUT; o++) begin : g_out
        logic signed [SUM_BITS-1:0] scaled, biased, sat;

        if (SHIFT > 0) begin : g_round
            assign scaled = (SUM_BITS'(acc[o]) + SUM_BITS'(1 <<< (SHIFT-1))) >>> SHIFT;
        end else begin : g_noround
            assign scaled = SUM_BITS'(acc[o]);
        end

        assign biased = scaled + SUM_BITS'(mem[NUM_W+o]);

        always_comb begin
            if (biased > SAT_MAX)      sat = SAT_MAX;
            else if (biased < SAT_MIN) sat = SAT_MIN;
            else                       sat = biased;
            if (relu2 && (sat < 0))    sat = '0;
        end

        assign res[o] = sat[DATA_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= v2;
            frame_done <= v2 && last2;
            if (v2) begin
                for (int o = 0; o < CH_OUT; o++) begin
                    data_out[o*DATA_BITS +: DATA_BITS] <= res[o];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_layer_param.sv
// ============================================================================
// Module      : tb_conv_layer_param
// Description : Self-checking bench for conv_layer_param against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_layer_param;

    localparam int W = 12, H = 12, CH_IN = 3, CH_OUT = 3, K = 3;
    localparam int DB = 12, WB = 8, SHIFT = 1;
    localparam int NW = CH_OUT * CH_IN * K * K;
    localparam int ADDR_W = $clog2(NW + CH_OUT);
    localparam int OW = W - K + 1, OH = H - K + 1, NOUT = OW * OH;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    logic                   clk = 1'b0;
    logic                   rst, valid_in, relu_en, cfg_we;
    logic [CH_IN*DB-1:0]    data_in;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [WB-1:0]          cfg_data;
    logic [CH_OUT*DB-1:0]   data_out;
    logic                   valid_out, frame_done, cfg_err;

    always #5 clk = ~clk;

    conv_layer_param dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .relu_en    (relu_en),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    int wt [CH_OUT][CH_IN][K][K];
    int bias [CH_OUT];
    int pix [CH_IN][H][W];
    int checks = 0, errors = 0;
    int cyc = 0;

    logic [CH_OUT*DB-1:0] got_q [$];
    bit                   done_q [$];
    int                   got_cyc [$];
    int                   err_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (valid_out) begin
            got_q.push_back(data_out);
            done_q.push_back(frame_done);
            got_cyc.push_back(cyc);
        end
        if (cfg_err) err_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference output for window with top-left corner (r, c).
    function automatic logic [CH_OUT*DB-1:0] ref_out(input int r, input int c, input bit relu);
        logic [CH_OUT*DB-1:0] v;
        longint acc, s, t;
        v = '0;
        for (int o = 0; o < CH_OUT; o++) begin
            acc = 0;
            for (int i = 0; i < CH_IN; i++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        acc += longint'(pix[i][r+ky][c+kx]) * longint'(wt[o][i][ky][kx]);
            if (SHIFT > 0) s = (acc + (longint'(1) << RND_SH)) >>> SHIFT;
            else           s = acc;
            t = s + bias[o];
            if (t > 2047)  t = 2047;
            if (t < -2048) t = -2048;
            if (relu && t < 0) t = 0;
            v[o*DB +: DB] = t[DB-1:0];
        end
        return v;
    endfunction

    task automatic cfg_write(input int addr, input int val);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_data = WB'(val);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic load_all();
        for (int o = 0; o < CH_OUT; o++)
            for (int i = 0; i < CH_IN; i++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        cfg_write((o*CH_IN+i)*K*K + ky*K + kx, wt[o][i][ky][kx]);
        for (int o = 0; o < CH_OUT; o++) cfg_write(NW + o, bias[o]);
    endtask

    task automatic set_weights(input int val, input int b);
        for (int o = 0; o < CH_OUT; o++) begin
            bias[o] = b;
            for (int i = 0; i < CH_IN; i++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        wt[o][i][ky][kx] = val;
        end
    endtask

    task automatic set_pixels(input int val);
        for (int i = 0; i < CH_IN; i++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    pix[i][r][c] = val;
    endtask

    task automatic clear_q();
        got_q.delete();
        done_q.delete();
        got_cyc.delete();
        err_cyc.delete();
    endtask

    task automatic run_frame(input bit gaps, input int npix, input bit relu,
                             input int inj_idx, input int inj_addr, input int inj_val,
                             output int t22, output int inj_cyc);
        int r, c;
        t22 = -1;
        inj_cyc = -1;
        relu_en = relu;
        for (int p = 0; p < npix; p++) begin
            r = p / W;
            c = p % W;
            valid_in = 1'b1;
            for (int i = 0; i < CH_IN; i++) data_in[i*DB +: DB] = DB'(pix[i][r][c]);
            if (p == inj_idx) begin
                cfg_we   = 1'b1;
                cfg_addr = ADDR_W'(inj_addr);
                cfg_data = WB'(inj_val);
                inj_cyc  = cyc + 1;
            end
            if (r == K - 1 && c == K - 1) t22 = cyc + 1;
            @(negedge clk);
            valid_in = 1'b0;
            cfg_we   = 1'b0;
            if (gaps) @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input bit relu, input int t22);
        int r, c;
        check({tag, "_count"}, 64'(got_q.size()), 64'(NOUT));
        for (int k = 0; k < NOUT; k++) begin
            r = k / OW;
            c = k % OW;
            check($sformatf("%s_out%0d", tag, k), 64'(got_q[k]), 64'(ref_out(r, c, relu)));
            check($sformatf("%s_done%0d", tag, k), 64'(done_q[k]), 64'(k == NOUT - 1));
        end
        check({tag, "_latency"}, 64'(got_cyc[0]), 64'(t22 + 3));
    endtask

    int t22, icyc;
    bit rl;

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; relu_en = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_cfg_err", 64'(cfg_err), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Unit weights on constant ones: (27+1)>>>1 = 14.
        set_weights(1, 0); load_all(); set_pixels(1); clear_q();
        run_frame(0, H*W, 0, -1, 0, 0, t22, icyc);
        check("ones_first", 64'(got_q[0]), 64'({CH_OUT{12'd14}}));
        check_frame("ones", 0, t22);

        set_weights(127, 0); load_all(); set_pixels(2047); clear_q();
        run_frame(0, H*W, 0, -1, 0, 0, t22, icyc);
        check("satpos_first", 64'(got_q[0]), 64'({CH_OUT{12'h7ff}}));
        check_frame("satpos", 0, t22);

        set_weights(-128, 0); load_all(); clear_q();
        run_frame(0, H*W, 0, -1, 0, 0, t22, icyc);
        check("satneg_first", 64'(got_q[0]), 64'({CH_OUT{12'h800}}));
        check_frame("satneg", 0, t22);

        clear_q();
        run_frame(0, H*W, 1, -1, 0, 0, t22, icyc);
        check("relu_first", 64'(got_q[0]), 64'(0));
        check_frame("relu", 1, t22);

        // Centre tap 2 on matching channel, bias -3, ramp input.
        set_weights(0, -3);
        for (int o = 0; o < CH_OUT; o++) wt[o][o][1][1] = 2;
        load_all();
        for (int i = 0; i < CH_IN; i++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    pix[i][r][c] = r * W + c;
        clear_q();
        run_frame(0, H*W, 0, -1, 0, 0, t22, icyc);
        check("ramp_first", 64'(got_q[0]), 64'({CH_OUT{12'd10}}));
        check_frame("ramp", 0, t22);

        clear_q();
        run_frame(1, H*W, 0, -1, 0, 0, t22, icyc);
        check_frame("gaps", 0, t22);

        // Abort a frame with reset, then a full clean frame.
        run_frame(0, 50, 0, -1, 0, 0, t22, icyc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_q();
        run_frame(0, H*W, 0, -1, 0, 0, t22, icyc);
        check_frame("after_rst", 0, t22);

        // Write during a frame is rejected; the same write while idle lands.
        clear_q();
        run_frame(0, H*W, 0, 20, 4, 5, t22, icyc);
        check("busy_err_count", 64'(err_cyc.size()), 64'(1));
        check("busy_err_cycle", 64'(err_cyc[0]), 64'(icyc));
        check_frame("busy_write", 0, t22);

        cfg_write(4, 5);
        wt[0][0][1][1] = 5;
        clear_q();
        run_frame(0, H*W, 0, -1, 0, 0, t22, icyc);
        check("idle_err_count", 64'(err_cyc.size()), 64'(0));
        check_frame("idle_write", 0, t22);

        for (int f = 0; f < 3; f++) begin
            for (int o = 0; o < CH_OUT; o++) begin
                bias[o] = int'($urandom_range(0, 255)) - 128;
                for (int i = 0; i < CH_IN; i++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            wt[o][i][ky][kx] = int'($urandom_range(0, 255)) - 128;
            end
            for (int i = 0; i < CH_IN; i++)
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        pix[i][r][c] = (f == 2) ? int'($urandom_range(0, 4095)) - 2048
                                                : int'($urandom_range(0, 63)) - 32;
            load_all();
            rl = 1'($urandom_range(0, 1));
            clear_q();
            run_frame(1'($urandom_range(0, 1)), H*W, rl, -1, 0, 0, t22, icyc);
            check_frame($sformatf("rand%0d", f), rl, t22);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
